// File: rtl/apb_ucpd_rx_bit_rec.sv
// -----------------------------------------------------------------------------
// apb_ucpd_rx_bit_rec
//
// USB-PD BMC receive bit recovery. The CC line is sampled once per
// ucpd_clk_red pulse. The preamble is used to train the half-bit length, then
// edge intervals are classified against a 1.5 half-bit threshold to recover
// the bit stream.
//
// Optional build macro:
//   UCPD_RX_GLITCH_FILT_EN - put a 3-sample majority filter (clocked by
//                            ucpd_clk_red) in front of edge detection. This
//                            rejects single-sample pulses and adds two
//                            samples of latency.
//
// Ports:
//   ic_clk       in   processor clock, all state changes on its rising edge
//   ic_rst       in   synchronous active-high reset
//   ucpd_clk_red in   sample enable, one-cycle pulse per UCPD_CLK period
//   rx_en        in   receiver enable
//   cc_in        in   CC line, already synchronised to ic_clk
//   rx_idle_lim  in   [7:0] samples without an edge that declare the line idle
//   rx_bit       out  decoded bit, held until the next rx_bit_vld
//   rx_bit_vld   out  one-cycle pulse, rx_bit is valid
//   rx_err       out  one-cycle pulse on a BMC coding violation
//   rx_done      out  one-cycle pulse when the line goes idle after DECODE
//   rx_active    out  high while not IDLE
//   hbit_len     out  [7:0] trained half-bit length in samples
// -----------------------------------------------------------------------------
module apb_ucpd_rx_bit_rec (
    input  logic       ic_clk,
    input  logic       ic_rst,
    input  logic       ucpd_clk_red,
    input  logic       rx_en,
    input  logic       cc_in,
    input  logic [7:0] rx_idle_lim,
    output logic       rx_bit,
    output logic       rx_bit_vld,
    output logic       rx_err,
    output logic       rx_done,
    output logic       rx_active,
    output logic [7:0] hbit_len
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_TRAIN  = 2'd1,
        ST_DECODE = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic       prev_q, prev_d;       // previous (reference) line sample
    logic [7:0] cnt_q, cnt_d;         // samples since the last edge
    logic [7:0] min_q, min_d;         // shortest interval seen in TRAIN
    logic [2:0] train_q, train_d;     // edges counted in TRAIN
    logic [8:0] thresh_q, thresh_d;   // half/full interval decision point
    logic       half_q, half_d;       // first half of a '1' already seen
    logic [7:0] hbit_q, hbit_d;
    logic       bit_q, bit_d;
    logic       vld_q, vld_d;
    logic       err_q, err_d;
    logic       done_q, done_d;
    logic       active_q, active_d;

    logic       line_s;
    logic       edge_s;
    logic [7:0] cnt_inc_s;
    logic       idle_hit_s;
    logic [7:0] min_upd_s;
    logic [8:0] thresh_calc_s;

`ifdef UCPD_RX_GLITCH_FILT_EN
    logic [2:0] filt_q, filt_d;

    function automatic logic maj3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

    // Shift the raw line into the majority window once per sample.
    always_comb begin
        filt_d = filt_q;
        if (ucpd_clk_red) begin
            filt_d = {filt_q[1:0], cc_in};
        end else begin
            filt_d = filt_q;
        end
    end

    // Majority filter window register.
    always_ff @(posedge ic_clk) begin
        if (ic_rst) begin
            filt_q <= 3'b000;
        end else begin
            filt_q <= filt_d;
        end
    end

    // Only registered samples vote, so a clean step shows up two samples late.
    assign line_s = maj3(filt_q);
`else
    assign line_s = cc_in;
`endif

    assign edge_s        = ucpd_clk_red && (line_s != prev_q);
    assign cnt_inc_s     = (cnt_q == 8'hFF) ? 8'hFF : (cnt_q + 8'd1);
    // The counter reaching the limit on this sample wins over an edge on it.
    assign idle_hit_s    = ucpd_clk_red && (cnt_inc_s >= rx_idle_lim);
    // cnt_q already holds the interval ending at this sample (edge sample = 1).
    assign min_upd_s     = (cnt_q < min_q) ? cnt_q : min_q;
    assign thresh_calc_s = {1'b0, min_upd_s} + {2'b00, min_upd_s[7:1]};

    // Next-state and output decode for the IDLE/TRAIN/DECODE machine.
    always_comb begin
        state_d  = state_q;
        prev_d   = prev_q;
        cnt_d    = cnt_q;
        min_d    = min_q;
        train_d  = train_q;
        thresh_d = thresh_q;
        half_d   = half_q;
        hbit_d   = hbit_q;
        bit_d    = bit_q;
        vld_d    = 1'b0;
        err_d    = 1'b0;
        done_d   = 1'b0;

        if (!rx_en) begin
            // Track the line while disabled so enabling is never an edge.
            state_d = ST_IDLE;
            prev_d  = line_s;
            cnt_d   = 8'd0;
            train_d = 3'd0;
            half_d  = 1'b0;
        end else begin
            if (ucpd_clk_red) begin
                prev_d = line_s;
                cnt_d  = edge_s ? 8'd1 : cnt_inc_s;
            end else begin
                prev_d = prev_q;
                cnt_d  = cnt_q;
            end

            case (state_q)
                ST_IDLE: begin
                    if (edge_s) begin
                        state_d = ST_TRAIN;
                        min_d   = 8'hFF;
                        train_d = 3'd0;
                        half_d  = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_TRAIN: begin
                    if (idle_hit_s) begin
                        state_d = ST_IDLE;
                        train_d = 3'd0;
                    end else if (edge_s) begin
                        min_d = min_upd_s;
                        if (train_q == 3'd7) begin
                            state_d  = ST_DECODE;
                            hbit_d   = min_upd_s;
                            thresh_d = thresh_calc_s;
                            train_d  = 3'd0;
                            half_d   = 1'b0;
                        end else begin
                            train_d = train_q + 3'd1;
                        end
                    end else begin
                        state_d = ST_TRAIN;
                    end
                end
                ST_DECODE: begin
                    if (idle_hit_s) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                        half_d  = 1'b0;
                    end else if (edge_s) begin
                        if ({1'b0, cnt_q} >= thresh_q) begin
                            // Full interval: a '0', or a violation if a half was pending.
                            vld_d  = 1'b1;
                            bit_d  = 1'b0;
                            err_d  = half_q;
                            half_d = 1'b0;
                        end else if (half_q) begin
                            vld_d  = 1'b1;
                            bit_d  = 1'b1;
                            half_d = 1'b0;
                        end else begin
                            half_d = 1'b1;
                        end
                    end else begin
                        state_d = ST_DECODE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    half_d  = 1'b0;
                    train_d = 3'd0;
                end
            endcase
        end

        active_d = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge ic_clk) begin
        if (ic_rst) begin
            state_q  <= ST_IDLE;
            prev_q   <= 1'b0;
            cnt_q    <= 8'd0;
            min_q    <= 8'd0;
            train_q  <= 3'd0;
            thresh_q <= 9'd0;
            half_q   <= 1'b0;
            hbit_q   <= 8'd0;
            bit_q    <= 1'b0;
            vld_q    <= 1'b0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            prev_q   <= prev_d;
            cnt_q    <= cnt_d;
            min_q    <= min_d;
            train_q  <= train_d;
            thresh_q <= thresh_d;
            half_q   <= half_d;
            hbit_q   <= hbit_d;
            bit_q    <= bit_d;
            vld_q    <= vld_d;
            err_q    <= err_d;
            done_q   <= done_d;
            active_q <= active_d;
        end
    end

    assign rx_bit     = bit_q;
    assign rx_bit_vld = vld_q;
    assign rx_err     = err_q;
    assign rx_done    = done_q;
    assign rx_active  = active_q;
    assign hbit_len   = hbit_q;

endmodule

// File: tb/tb_apb_ucpd_rx_bit_rec.sv
module tb_apb_ucpd_rx_bit_rec;

    logic       ic_clk = 1'b0;
    logic       ic_rst;
    logic       ucpd_clk_red;
    logic       rx_en;
    logic       cc_in;
    logic [7:0] rx_idle_lim;
    logic       rx_bit;
    logic       rx_bit_vld;
    logic       rx_err;
    logic       rx_done;
    logic       rx_active;
    logic [7:0] hbit_len;

    apb_ucpd_rx_bit_rec dut (
        .ic_clk       (ic_clk),
        .ic_rst       (ic_rst),
        .ucpd_clk_red (ucpd_clk_red),
        .rx_en        (rx_en),
        .cc_in        (cc_in),
        .rx_idle_lim  (rx_idle_lim),
        .rx_bit       (rx_bit),
        .rx_bit_vld   (rx_bit_vld),
        .rx_err       (rx_err),
        .rx_done      (rx_done),
        .rx_active    (rx_active),
        .hbit_len     (hbit_len)
    );

    always #5 ic_clk = ~ic_clk;

    int n_chk  = 0;
    int n_fail = 0;
    int div    = 1;      // ic_clk cycles per sample
    logic line = 1'b1;   // current driven line level

    // Output monitor, sampled on the falling edge.
    int vld_cnt  = 0;
    int err_cnt  = 0;
    int done_cnt = 0;
    bit bit_hist [0:1023];

    always @(negedge ic_clk) begin
        if (rx_bit_vld === 1'b1) begin
            bit_hist[vld_cnt] = rx_bit;
            vld_cnt++;
        end
        if (rx_err === 1'b1) err_cnt++;
        if (rx_done === 1'b1) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] get_bits(input int base, input int n);
        logic [31:0] v;
        v = 32'd0;
        for (int i = 0; i < n; i++) v[i] = bit_hist[base + i];
        return v;
    endfunction

    // One line sample: drive at the falling edge, pulse ucpd_clk_red once per div cycles.
    task automatic drive_sample(input logic lvl);
        @(negedge ic_clk);
        cc_in        = lvl;
        ucpd_clk_red = 1'b1;
        for (int j = 1; j < div; j++) begin
            @(negedge ic_clk);
            ucpd_clk_red = 1'b0;
        end
    endtask

    task automatic hold(input logic lvl, input int n);
        for (int k = 0; k < n; k++) drive_sample(lvl);
    endtask

    // Toggle the line and hold it for n samples.
    task automatic tog(input int n);
        line = ~line;
        hold(line, n);
    endtask

    // Eight alternating half-bits; the last trained interval ends at the first data edge.
    task automatic send_preamble(input int h);
        for (int k = 0; k < 8; k++) tog(h);
    endtask

    // BMC bits LSB-first; each bit is decoded at the next bit's boundary edge.
    task automatic send_bits(input logic [7:0] data, input int n, input int h);
        for (int k = 0; k < n; k++) begin
            if (data[k]) begin
                tog(h);
                tog(h);
            end else begin
                tog(2 * h);
            end
        end
    endtask

    int vb, eb, db;

    initial begin
        ic_rst       = 1'b1;
        ucpd_clk_red = 1'b0;
        rx_en        = 1'b0;
        cc_in        = 1'b1;
        rx_idle_lim  = 8'd30;

        // Reset state
        repeat (2) @(posedge ic_clk);
        #1;
        chk("rst_bit",    32'(rx_bit),     32'd0);
        chk("rst_vld",    32'(rx_bit_vld), 32'd0);
        chk("rst_err",    32'(rx_err),     32'd0);
        chk("rst_done",   32'(rx_done),    32'd0);
        chk("rst_active", 32'(rx_active),  32'd0);
        chk("rst_hbit",   32'(hbit_len),   32'd0);
        @(negedge ic_clk);
        ic_rst = 1'b0;
        hold(line, 5);
        @(negedge ic_clk);
        rx_en = 1'b1;
        hold(line, 5);

        // Preamble + 0x5A at half-bit 10, then idle 40 samples
        vb = vld_cnt; eb = err_cnt; db = done_cnt;
        send_preamble(10);
        send_bits(8'h5A, 8, 10);
        chk("a_active", 32'(rx_active), 32'd1);
        chk("a_hbit",   32'(hbit_len),  32'd10);
        tog(40);
        chk("a_nbits",  32'(vld_cnt - vb),  32'd8);
        chk("a_bits",   get_bits(vb, 8),    32'h5A);
        chk("a_err",    32'(err_cnt - eb),  32'd0);
        chk("a_done",   32'(done_cnt - db), 32'd1);
        chk("a_idle",   32'(rx_active),     32'd0);

        // Half interval then full interval: coding violation
        vb = vld_cnt; eb = err_cnt; db = done_cnt;
        send_preamble(10);
        tog(10);
        tog(20);
        line = ~line;
        drive_sample(line);
`ifdef UCPD_RX_GLITCH_FILT_EN
        drive_sample(line);
        drive_sample(line);
`endif
        @(posedge ic_clk);
        #1;
        chk("b_vld_lat", 32'(rx_bit_vld), 32'd1);
        chk("b_err_lat", 32'(rx_err),     32'd1);
        chk("b_bit",     32'(rx_bit),     32'd0);
        hold(line, 37);
        chk("b_err",  32'(err_cnt - eb),  32'd1);
        chk("b_nvld", 32'(vld_cnt - vb),  32'd1);
        chk("b_done", 32'(done_cnt - db), 32'd1);

        // Threshold boundary: 15 is a full interval, 14 a half
        vb = vld_cnt; eb = err_cnt;
        send_preamble(10);
        tog(15);
        tog(14);
        tog(14);
        tog(40);
        chk("c_nbits", 32'(vld_cnt - vb), 32'd2);
        chk("c_bits",  get_bits(vb, 2),   32'h2);
        chk("c_err",   32'(err_cnt - eb), 32'd0);

        // Reset mid-DECODE, then retrain on a new packet
        send_preamble(10);
        send_bits(8'hFF, 3, 10);
        chk("d_active_pre", 32'(rx_active), 32'd1);
        eb = err_cnt; db = done_cnt;
        @(negedge ic_clk);
        ic_rst = 1'b1;
        @(posedge ic_clk);
        #1;
        chk("d_bit",    32'(rx_bit),     32'd0);
        chk("d_vld",    32'(rx_bit_vld), 32'd0);
        chk("d_err",    32'(rx_err),     32'd0);
        chk("d_done",   32'(rx_done),    32'd0);
        chk("d_active", 32'(rx_active),  32'd0);
        chk("d_hbit",   32'(hbit_len),   32'd0);
        @(negedge ic_clk);
        ic_rst = 1'b0;
        rx_en  = 1'b0;
        hold(line, 5);
        @(negedge ic_clk);
        rx_en = 1'b1;
        hold(line, 5);
        chk("d_no_pulse", 32'((err_cnt - eb) + (done_cnt - db)), 32'd0);
        vb = vld_cnt; eb = err_cnt; db = done_cnt;
        send_preamble(10);
        send_bits(8'hC3, 8, 10);
        tog(40);
        chk("d2_hbit", 32'(hbit_len),       32'd10);
        chk("d2_bits", get_bits(vb, 8),     32'hC3);
        chk("d2_err",  32'(err_cnt - eb),   32'd0);
        chk("d2_done", 32'(done_cnt - db),  32'd1);

        // rx_en dropped mid-DECODE: IDLE next cycle, hbit_len kept, no rx_done
        send_preamble(10);
        send_bits(8'h0F, 2, 10);
        db = done_cnt;
        @(negedge ic_clk);
        rx_en = 1'b0;
        @(posedge ic_clk);
        #1;
        chk("e_active", 32'(rx_active), 32'd0);
        chk("e_hbit",   32'(hbit_len),  32'd10);
        hold(line, 40);
        chk("e_done", 32'(done_cnt - db), 32'd0);
        @(negedge ic_clk);
        rx_en = 1'b1;
        hold(line, 5);

        // Single-sample glitch in the middle of bit 0 of 0x5A
        vb = vld_cnt; eb = err_cnt;
        send_preamble(10);
        line = ~line;
        hold(line, 5);
        hold(~line, 1);
        hold(line, 14);
        send_bits(8'h2D, 7, 10);
        tog(40);
`ifdef UCPD_RX_GLITCH_FILT_EN
        chk("f_bits",  get_bits(vb, 8),   32'h5A);
        chk("f_nbits", 32'(vld_cnt - vb), 32'd8);
        chk("f_err",   32'(err_cnt - eb), 32'd0);
`else
        chk("f_corrupt",
            (((err_cnt - eb) != 0) || ((vld_cnt - vb) != 8) || (get_bits(vb, 8) != 32'h5A)) ? 32'd1 : 32'd0,
            32'd1);
`endif

        // Sample enable every 4th cycle, half-bit 6
        div = 4;
        hold(line, 3);
        vb = vld_cnt; eb = err_cnt; db = done_cnt;
        send_preamble(6);
        send_bits(8'h96, 8, 6);
        tog(40);
        chk("g_hbit",  32'(hbit_len),      32'd6);
        chk("g_nbits", 32'(vld_cnt - vb),  32'd8);
        chk("g_bits",  get_bits(vb, 8),    32'h96);
        chk("g_err",   32'(err_cnt - eb),  32'd0);
        chk("g_done",  32'(done_cnt - db), 32'd1);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
